shuffle_engine: RTL and testbench
=================================

Name: shuffle_engine

Overview:
- Parametrised, multi-cycle successor of the combinational ALU shuffle unit.
- Performs zip (interleave the two halves) or unzip (de-interleave) of a DATA_W-bit word at any power-of-two granularity.
- Executes one butterfly stage per cycle under a valid/ready handshake, so DATA_W can grow without a deep combinational mux.
- Sits beside the ALU datapath as a multi-cycle functional unit.

Parameters:
- DATA_W, 32, operand width; power of two, >= 8.
- STG (localparam), $clog2(DATA_W)-1, number of butterfly stages, indexed k = 0..STG-1.
- GRAN_W (localparam), $clog2(STG+1), width of the granularity field.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- in_data  in  DATA_W  operand.
- in_gran  in  GRAN_W  granularity G; chunk size g = 2^G bits.
- in_unzip  in  1  0 = zip, 1 = unzip.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Function, zip at granularity g, for each i:
  - out[2g*i +: g] = in[g*i +: g]
  - out[2g*i+g +: g] = in[DATA_W/2 + g*i +: g]
- Unzip is the exact inverse of zip.
- G = STG gives the identity.
- G > STG is treated as G = 0.
- Stage k: in every aligned 4*2^k-bit block, swap quarter 1 with quarter 2 (each quarter is 2^k bits).
- Stage order:
  - zip applies k = STG-1 down to G.
  - unzip applies k = G up to STG-1.
  - Stage count N = STG-G.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid, latch in_data into the work register, latch the direction, and set the stage counter to its first stage. Go to RUN if N > 0, else go to DONE.
  - RUN: apply one stage per cycle to the work register and step the counter. After the last stage, go to DONE.
  - DONE: out_valid=1 and out_data = work register, both held stable until out_ready. On out_ready, go to IDLE.
- Latency: out_valid asserts N+1 cycles after the accepting edge (identity case: 1 cycle).
- Throughput: one operation in flight. in_ready=0 in RUN and DONE; requests presented then are not accepted and must be held by the source.
- Backpressure: out_valid held indefinitely while out_ready=0. in_ready returns 1 the cycle after the out_ready handshake.
- out_ready outside DONE is ignored.
- Reset: all outputs 0 (in_ready=0 while rst is high, 1 the first cycle after), state IDLE, work register 0, counter 0. Reset mid-RUN or mid-DONE discards the operation with no output.

Optional Feature:
- Macro: SHUF_STAGE_MASK_EN.
- When defined:
  - Adds port in_mask (in, STG bits), latched on accept, giving generalised shfl/unshfl.
  - in_gran is ignored.
  - Stage k executes only if in_mask[k]=1, in the same zip/unzip order.
  - Cleared stages are skipped with no cycle cost.
  - N = popcount(in_mask); a zero mask gives 1-cycle identity.
- When undefined: port absent; the contiguous range G..STG-1 is used.

Decomposition:
- Package shuffle_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - a function computing STG from DATA_W;
  - a function applying stage k to a DATA_W vector.
- One natural sub-module: shuffle_stage. It is combinational, with inputs data and a one-hot/indexed stage select, and returns the stage-swapped word. It is instantiated once and muxed by the counter.

Test Plan:
- DATA_W=32, zip, G=0, in_data=0x0000FFFF -> out_data=0x55555555; out_valid 5 cycles after accept.
- Unzip, G=0, in_data=0x55555555 -> 0x0000FFFF. Random-data zip followed by unzip at each G in 0..4 returns the original.
- Zip, G=3, in_data=0xAABBCCDD -> 0xAACCBBDD after 2 cycles.
- G=4 -> out_data=in_data after 1 cycle.
- G=7 behaves exactly as G=0.
- Hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; the new request is accepted only after the handshake.
- Assert rst during RUN -> next cycle IDLE, out_valid=0, no result emitted.
- A following request completes normally.
- With SHUF_STAGE_MASK_EN: zip, mask=4'b0101 on 0x0000FFFF -> result matches a stage-2-then-stage-0 golden model, latency 3. mask=0 -> identity, latency 1.

Source files
------------

// File: rtl/shuffle_pkg.sv
// shuffle_pkg: shared state encoding and butterfly-stage helpers for shuffle_engine
package shuffle_pkg;

    localparam int MAX_W = 1024;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int stg_of(input int w);
        return $clog2(w) - 1;
    endfunction

    // Swap quarter 1 with quarter 2 of every aligned 4*2^k-bit block
    function automatic logic [MAX_W-1:0] stage_apply(input logic [MAX_W-1:0] d, input int k);
        logic [MAX_W-1:0] m;
        int q;
        q = 1 << k;
        m = '0;
        for (int i = 0; i < MAX_W; i++) m[i] = ((i >> k) & 3) == 1;
        return (d & ~(m | (m << q))) | ((d & m) << q) | ((d >> q) & m);
    endfunction

endpackage

// File: rtl/shuffle_stage.sv
// shuffle_stage: one combinational butterfly stage selected by index k
module shuffle_stage
    import shuffle_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KW = 2
) (
    input  logic [DATA_W-1:0] data,
    input  logic [KW-1:0]     k,
    output logic [DATA_W-1:0] q
);

    assign q = DATA_W'(stage_apply(MAX_W'(data), int'(k)));

endmodule

// File: rtl/shuffle_engine.sv
// shuffle_engine: multi-cycle zip/unzip unit, one butterfly stage per cycle.
// Define SHUF_STAGE_MASK_EN to replace in_gran with a per-stage in_mask port.
module shuffle_engine
    import shuffle_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int STG = stg_of(DATA_W),
    localparam int GRAN_W = $clog2(STG + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [GRAN_W-1:0] in_gran,
    input  logic              in_unzip,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
`ifdef SHUF_STAGE_MASK_EN
    ,
    input  logic [STG-1:0]    in_mask
`endif
);

    localparam int KW = (STG > 1) ? $clog2(STG) : 1;

    state_t            state;
    logic [DATA_W-1:0] work, staged;
    logic [KW-1:0]     cnt, first, nxt;
    logic [STG-1:0]    mask_r, eff;
    logic              unzip_r, has_first, has_nxt;

    shuffle_stage #(.DATA_W(DATA_W), .KW(KW)) u_stage (.data(work), .k(cnt), .q(staged));

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign out_data  = work;

    // Zip walks set stages downward, unzip upward; gaps cost no cycles
    always_comb begin
        eff = '0;
        first = '0;
        has_first = 1'b0;
        nxt = '0;
        has_nxt = 1'b0;
`ifdef SHUF_STAGE_MASK_EN
        eff = in_mask;
`else
        for (int i = 0; i < STG; i++)
            eff[i] = (int'(in_gran) > STG) ? 1'b1 : (i >= int'(in_gran));
`endif
        for (int i = 0; i < STG; i++) begin
            if (eff[i] && !(in_unzip && has_first)) begin
                first = KW'(i);
                has_first = 1'b1;
            end
            if (mask_r[i] && (unzip_r ? (i > int'(cnt) && !has_nxt) : (i < int'(cnt)))) begin
                nxt = KW'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            mask_r  <= '0;
            unzip_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work    <= in_data;
                    unzip_r <= in_unzip;
                    mask_r  <= eff;
                    cnt     <= first;
                    state   <= has_first ? RUN : DONE;
                end
                RUN: begin
                    work <= staged;
                    if (has_nxt) cnt <= nxt;
                    else state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shuffle_engine.sv
// tb_shuffle_engine: directed self-checking bench for shuffle_engine (DATA_W=32)
module tb_shuffle_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_unzip = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_gran = '0;
    logic        in_ready, out_valid, busy;
    logic [31:0] out_data;
`ifdef SHUF_STAGE_MASK_EN
    logic [3:0]  in_mask = '0;
    bit          use_mask = 1'b0;
`endif

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    shuffle_engine #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_gran(in_gran), .in_unzip(in_unzip),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef SHUF_STAGE_MASK_EN
        , .in_mask(in_mask)
`endif
    );

    function automatic logic [31:0] ref_shuf(input logic [31:0] d, input int gr, input bit unz);
        int gg;
        logic [31:0] r;
        gg = 1 << ((gr > 4) ? 0 : gr);
        r = '0;
        for (int x = 0; x < 16; x++) begin
            int a;
            a = 2 * gg * (x / gg) + (x % gg);
            if (unz) begin
                r[x] = d[a];
                r[16 + x] = d[a + gg];
            end else begin
                r[a] = d[x];
                r[a + gg] = d[16 + x];
            end
        end
        return r;
    endfunction

    task automatic run_op(input logic [31:0] d, input logic [2:0] gr, input bit unz,
                          output logic [31:0] res, output int lat);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1; t++;
        end
`ifdef SHUF_STAGE_MASK_EN
        if (!use_mask) in_mask = 4'hF << ((gr > 4) ? 0 : gr);
`endif
        in_data = d; in_gran = gr; in_unzip = unz; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            ncmp++; nerr++;
            $display("FAIL op_timeout: out_valid=%b after %0d cycles, required 1", out_valid, lat);
        end
        res = out_data;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ncmp++;
        if ({in_ready, out_valid, busy} !== 3'b000 || out_data !== 32'h0) begin
            nerr++;
            $display("FAIL reset_outputs: rdy/vld/busy=%b data=%h, required 000 00000000", {in_ready, out_valid, busy}, out_data);
        end
        rst = 1'b0;
        #1;
        ncmp++;
        if (in_ready !== 1'b1) begin
            nerr++;
            $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_zip_unzip_g0();
        logic [31:0] r;
        int lat;
        run_op(32'h0000FFFF, 3'd0, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'h55555555 || lat !== 5) begin
            nerr++;
            $display("FAIL zip_g0: data=%h lat=%0d, required 55555555 lat=5", r, lat);
        end
        run_op(32'h55555555, 3'd0, 1'b1, r, lat);
        ncmp++;
        if (r !== 32'h0000FFFF || lat !== 5) begin
            nerr++;
            $display("FAIL unzip_g0: data=%h lat=%0d, required 0000ffff lat=5", r, lat);
        end
    endtask

    task automatic test_zip_g3_identity_overflow();
        logic [31:0] r;
        int lat;
        run_op(32'hAABBCCDD, 3'd3, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'hAACCBBDD || lat !== 2) begin
            nerr++;
            $display("FAIL zip_g3: data=%h lat=%0d, required aaccbbdd lat=2", r, lat);
        end
        run_op(32'hDEADBEEF, 3'd4, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'hDEADBEEF || lat !== 1) begin
            nerr++;
            $display("FAIL identity_g4: data=%h lat=%0d, required deadbeef lat=1", r, lat);
        end
        run_op(32'h0000FFFF, 3'd7, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'h55555555 || lat !== 5) begin
            nerr++;
            $display("FAIL gran7_as_g0: data=%h lat=%0d, required 55555555 lat=5", r, lat);
        end
    endtask

    task automatic test_roundtrip();
        logic [31:0] vec [5] = '{32'h12345678, 32'hCAFEF00D, 32'h0F1E2D3C, 32'h89ABCDEF, 32'h31415926};
        logic [31:0] z, u;
        int lat;
        for (int gi = 0; gi < 5; gi++) begin
            run_op(vec[gi], 3'(gi), 1'b0, z, lat);
            ncmp++;
            if (z !== ref_shuf(vec[gi], gi, 1'b0) || lat !== 5 - gi) begin
                nerr++;
                $display("FAIL zip_g%0d: data=%h lat=%0d, required %h lat=%0d", gi, z, lat, ref_shuf(vec[gi], gi, 1'b0), 5 - gi);
            end
            run_op(z, 3'(gi), 1'b1, u, lat);
            ncmp++;
            if (u !== vec[gi] || lat !== 5 - gi) begin
                nerr++;
                $display("FAIL roundtrip_g%0d: data=%h lat=%0d, required %h lat=%0d", gi, u, lat, vec[gi], 5 - gi);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        logic ok;
`ifdef SHUF_STAGE_MASK_EN
        in_mask = 4'hF;
`endif
        in_data = 32'h0000FFFF; in_gran = 3'd0; in_unzip = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 32'h12345678; in_gran = 3'd4;
`ifdef SHUF_STAGE_MASK_EN
        in_mask = 4'h0;
`endif
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1; t++;
        end
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_data !== 32'h55555555 || in_ready !== 1'b0) ok = 1'b0;
        end
        ncmp++;
        if (!ok) begin
            nerr++;
            $display("FAIL backpressure_hold: vld=%b data=%h rdy=%b, required 1 55555555 0", out_valid, out_data, in_ready);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        ncmp++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            nerr++;
            $display("FAIL after_handshake: vld/rdy/busy=%b, required 010", {out_valid, in_ready, busy});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ncmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h12345678) begin
            nerr++;
            $display("FAIL held_request: vld=%b data=%h, required 1 12345678", out_valid, out_data);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] r;
        int lat;
        logic seen;
`ifdef SHUF_STAGE_MASK_EN
        in_mask = 4'hF;
`endif
        in_data = 32'hFFFF0000; in_gran = 3'd0; in_unzip = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        ncmp++;
        if ({out_valid, busy, in_ready} !== 3'b001) begin
            nerr++;
            $display("FAIL reset_mid_run: vld/busy/rdy=%b, required 001", {out_valid, busy, in_ready});
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        ncmp++;
        if (seen !== 1'b0) begin
            nerr++;
            $display("FAIL discarded_result: out_valid seen=%b, required 0", seen);
        end
        run_op(32'hFFFF0000, 3'd0, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'hAAAAAAAA || lat !== 5) begin
            nerr++;
            $display("FAIL after_reset_op: data=%h lat=%0d, required aaaaaaaa lat=5", r, lat);
        end
    endtask

`ifdef SHUF_STAGE_MASK_EN
    task automatic test_mask();
        logic [31:0] r;
        int lat;
        use_mask = 1'b1;
        in_mask = 4'b0101;
        run_op(32'h0000FFFF, 3'd0, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'h0000FFFF || lat !== 3) begin
            nerr++;
            $display("FAIL mask0101_a: data=%h lat=%0d, required 0000ffff lat=3", r, lat);
        end
        run_op(32'h12345678, 3'd0, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'h15423768 || lat !== 3) begin
            nerr++;
            $display("FAIL mask0101_b: data=%h lat=%0d, required 15423768 lat=3", r, lat);
        end
        in_mask = 4'b0000;
        run_op(32'h12345678, 3'd0, 1'b0, r, lat);
        ncmp++;
        if (r !== 32'h12345678 || lat !== 1) begin
            nerr++;
            $display("FAIL mask_zero: data=%h lat=%0d, required 12345678 lat=1", r, lat);
        end
        use_mask = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_zip_unzip_g0();
        test_zip_g3_identity_overflow();
        test_roundtrip();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SHUF_STAGE_MASK_EN
        test_mask();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
